// File: rtl/sd_pkg.sv
// ============================================================================
// Module : sd_pkg
// Brief  : Shared state encoding and protocol constants for the SD SPI emulator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sd_pkg;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_CMD_ARGS   = 4'd1,
        S_NCR        = 4'd2,
        S_RESPOND    = 4'd3,
        S_READ_DELAY = 4'd4,
        S_READ_TOKEN = 4'd5,
        S_READ_DATA  = 4'd6,
        S_READ_CRC   = 4'd7,
        S_WRITE_WAIT = 4'd8,
        S_WRITE_DATA = 4'd9,
        S_WRITE_CRC  = 4'd10,
        S_DATA_RESP  = 4'd11,
        S_BUSY       = 4'd12
    } state_t;

    localparam logic [5:0] C_CMD_GO_IDLE      = 6'd0;
    localparam logic [5:0] C_CMD_SEND_IF_COND = 6'd8;
    localparam logic [5:0] C_CMD_SET_BLOCKLEN = 6'd16;
    localparam logic [5:0] C_CMD_READ_SINGLE  = 6'd17;
    localparam logic [5:0] C_CMD_WRITE_SINGLE = 6'd24;
    localparam logic [5:0] C_CMD_SD_SEND_OP   = 6'd41;
    localparam logic [5:0] C_CMD_APP          = 6'd55;
    localparam logic [5:0] C_CMD_READ_OCR     = 6'd58;

    localparam logic [7:0]  C_TOKEN_START  = 8'hFE;
    localparam logic [7:0]  C_DATA_RESP_OK = 8'h05;
    localparam logic [31:0] C_OCR          = 32'hC0FF8000;

endpackage

`default_nettype wire

// File: rtl/spi_byte_slave.sv
// ============================================================================
// Module : spi_byte_slave
// Brief  : Synchronised SPI mode-0 slave; one received byte and one sent byte per slot.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_byte_slave (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cs_n,
    input  logic       i_sclk,
    input  logic       i_mosi,
    input  logic       i_tx_load,
    input  logic [7:0] i_tx_byte,
    output logic       o_active,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_tx_done,
    output logic       o_miso
);

    logic [1:0] r_cs_sync;
    logic [1:0] r_sclk_sync;
    logic [1:0] r_mosi_sync;
    logic       r_sclk_prev;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_sh;
    logic [7:0] r_tx_sh;
    logic [7:0] r_tx_pend;
    logic       r_tx_pend_v;

    logic       w_rise;
    logic       w_fall;
    logic [7:0] w_next;

    assign o_active = ~r_cs_sync[1];
    assign w_rise   = r_sclk_sync[1] & ~r_sclk_prev;
    assign w_fall   = ~r_sclk_sync[1] & r_sclk_prev;
    // A slot with nothing queued sends the idle pattern.
    assign w_next   = r_tx_pend_v ? r_tx_pend : 8'hFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_sync   <= 2'b11;
            r_sclk_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_sclk_prev <= 1'b0;
            r_bit_cnt   <= 3'd0;
            r_rx_sh     <= 7'd0;
            r_tx_sh     <= 8'hFF;
            r_tx_pend   <= 8'hFF;
            r_tx_pend_v <= 1'b0;
            o_rx_valid  <= 1'b0;
            o_rx_byte   <= 8'd0;
            o_tx_done   <= 1'b0;
            o_miso      <= 1'b1;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], i_cs_n};
            r_sclk_sync <= {r_sclk_sync[0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[0], i_mosi};
            r_sclk_prev <= r_sclk_sync[1];
            o_rx_valid  <= 1'b0;
            o_tx_done   <= 1'b0;
            if (!o_active) begin
                r_bit_cnt   <= 3'd0;
                r_tx_sh     <= 8'hFF;
                r_tx_pend_v <= 1'b0;
                o_miso      <= 1'b1;
            end else begin
                if (w_rise) begin
                    r_rx_sh   <= {r_rx_sh[5:0], r_mosi_sync[1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        o_rx_valid <= 1'b1;
                        o_rx_byte  <= {r_rx_sh, r_mosi_sync[1]};
                    end
                end
                if (w_fall) begin
                    // Byte boundary: launch the next byte's MSB on this falling edge.
                    if (r_bit_cnt == 3'd0) begin
                        o_miso      <= w_next[7];
                        r_tx_sh     <= {w_next[6:0], 1'b1};
                        o_tx_done   <= r_tx_pend_v;
                        r_tx_pend_v <= 1'b0;
                    end else begin
                        o_miso  <= r_tx_sh[7];
                        r_tx_sh <= {r_tx_sh[6:0], 1'b1};
                    end
                end
                if (i_tx_load) begin
                    r_tx_pend   <= i_tx_byte;
                    r_tx_pend_v <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sd_spi_card_emu.sv
// ============================================================================
// Module : sd_spi_card_emu
// Brief  : SD card emulator in SPI mode: command decode, single-block read/write.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_spi_card_emu
    import sd_pkg::*;
#(
    parameter int NcrBytes            = 1,
    parameter int ReadTokenDelayBytes = 2,
    parameter int BusyBytes           = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_cs_n,
    input  logic        sd_clk,
    input  logic        sd_mosi,
    output logic        sd_miso,
    output logic [31:0] mem_sector,
    output logic [8:0]  mem_index,
    input  logic [7:0]  mem_rdata,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic        initialized,
    output logic [31:0] status
);

    logic       w_active;
    logic       w_rx_valid;
    logic [7:0] w_rx_byte;
    logic       w_tx_done;

    state_t      r_state;
    state_t      r_after;
    logic [5:0]  r_cmd;
    logic [31:0] r_arg;
    logic [9:0]  r_cnt;
    logic        r_app;
    logic [39:0] r_resp;
    logic [2:0]  r_resp_left;
    logic        r_tx_load;
    logic [7:0]  r_tx_byte;

    logic [7:0]  w_r1;
    logic [39:0] w_resp;
    logic [2:0]  w_len;
    state_t      w_after;

    spi_byte_slave u_spi (
        .clk        (clk),
        .rst        (rst),
        .i_cs_n     (sd_cs_n),
        .i_sclk     (sd_clk),
        .i_mosi     (sd_mosi),
        .i_tx_load  (r_tx_load),
        .i_tx_byte  (r_tx_byte),
        .o_active   (w_active),
        .o_rx_valid (w_rx_valid),
        .o_rx_byte  (w_rx_byte),
        .o_tx_done  (w_tx_done),
        .o_miso     (sd_miso)
    );

    assign status = {28'd0, r_state};

    // Response bytes are left-aligned in w_resp; unused trailing bytes are idle.
    always_comb begin
        w_r1    = {7'd0, ~initialized};
        w_resp  = {w_r1, 32'hFFFF_FFFF};
        w_len   = 3'd1;
        w_after = S_IDLE;
        case (r_cmd)
            C_CMD_GO_IDLE:      w_resp[39:32] = 8'h01;
            C_CMD_SEND_IF_COND: begin
                w_resp = {8'h01, 8'h00, 8'h00, 8'h01, r_arg[7:0]};
                w_len  = 3'd5;
            end
            C_CMD_APP, C_CMD_SET_BLOCKLEN: w_resp[39:32] = w_r1;
            C_CMD_SD_SEND_OP:   w_resp[39:32] = r_app ? 8'h00 : (w_r1 | 8'h04);
            C_CMD_READ_OCR: begin
                w_resp = {w_r1, C_OCR};
                w_len  = 3'd5;
            end
            C_CMD_READ_SINGLE: begin
                w_resp[39:32] = initialized ? 8'h00 : C_DATA_RESP_OK;
                w_after       = initialized ? S_READ_DELAY : S_IDLE;
            end
            C_CMD_WRITE_SINGLE: begin
                w_resp[39:32] = initialized ? 8'h00 : C_DATA_RESP_OK;
                w_after       = initialized ? S_WRITE_WAIT : S_IDLE;
            end
            default:            w_resp[39:32] = w_r1 | 8'h04;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_after     <= S_IDLE;
            r_cmd       <= 6'd0;
            r_arg       <= 32'd0;
            r_cnt       <= 10'd0;
            r_app       <= 1'b0;
            r_resp      <= 40'd0;
            r_resp_left <= 3'd0;
            r_tx_load   <= 1'b0;
            r_tx_byte   <= 8'hFF;
            mem_sector  <= 32'd0;
            mem_index   <= 9'd0;
            mem_we      <= 1'b0;
            mem_wdata   <= 8'd0;
            initialized <= 1'b0;
        end else begin
            r_tx_load <= 1'b0;
            mem_we    <= 1'b0;
            if (!w_active) begin
                r_state <= S_IDLE;
                r_cnt   <= 10'd0;
            end else begin
                // Prefetch: once a data byte has been launched, point storage at the next one.
                if (w_tx_done && r_state == S_READ_DATA && mem_index != 9'd511)
                    mem_index <= mem_index + 9'd1;
                if (w_rx_valid) begin
                    r_tx_load <= 1'b1;
                    r_tx_byte <= 8'hFF;
                    case (r_state)
                        S_IDLE: begin
                            if (w_rx_byte[7:6] == 2'b01) begin
                                r_cmd   <= w_rx_byte[5:0];
                                r_cnt   <= 10'd0;
                                r_state <= S_CMD_ARGS;
                            end
                        end
                        S_CMD_ARGS: begin
                            if (r_cnt != 10'd4) begin
                                r_arg <= {r_arg[23:0], w_rx_byte};
                                r_cnt <= r_cnt + 10'd1;
                            end else begin
                                r_app   <= (r_cmd == C_CMD_APP);
                                r_after <= w_after;
                                if (r_cmd == C_CMD_GO_IDLE)
                                    initialized <= 1'b0;
                                if (r_cmd == C_CMD_SD_SEND_OP && r_app)
                                    initialized <= 1'b1;
                                if ((r_cmd == C_CMD_READ_SINGLE || r_cmd == C_CMD_WRITE_SINGLE)
                                    && initialized) begin
                                    mem_sector <= r_arg;
                                    mem_index  <= 9'd0;
                                end
                                if (NcrBytes == 0) begin
                                    r_tx_byte   <= w_resp[39:32];
                                    r_resp      <= {w_resp[31:0], 8'hFF};
                                    r_resp_left <= w_len - 3'd1;
                                    r_state     <= S_RESPOND;
                                end else begin
                                    r_resp      <= w_resp;
                                    r_resp_left <= w_len;
                                    r_cnt       <= 10'd1;
                                    r_state     <= S_NCR;
                                end
                            end
                        end
                        S_NCR: begin
                            if (r_cnt == 10'(NcrBytes)) begin
                                r_tx_byte   <= r_resp[39:32];
                                r_resp      <= {r_resp[31:0], 8'hFF};
                                r_resp_left <= r_resp_left - 3'd1;
                                r_state     <= S_RESPOND;
                            end else begin
                                r_cnt <= r_cnt + 10'd1;
                            end
                        end
                        S_RESPOND: begin
                            if (r_resp_left != 3'd0) begin
                                r_tx_byte   <= r_resp[39:32];
                                r_resp      <= {r_resp[31:0], 8'hFF};
                                r_resp_left <= r_resp_left - 3'd1;
                            end else begin
                                case (r_after)
                                    S_READ_DELAY: begin
                                        if (ReadTokenDelayBytes == 0) begin
                                            r_tx_byte <= C_TOKEN_START;
                                            r_state   <= S_READ_TOKEN;
                                        end else begin
                                            r_cnt   <= 10'd1;
                                            r_state <= S_READ_DELAY;
                                        end
                                    end
                                    S_WRITE_WAIT: r_state <= S_WRITE_WAIT;
                                    default:      r_state <= S_IDLE;
                                endcase
                            end
                        end
                        S_READ_DELAY: begin
                            if (r_cnt == 10'(ReadTokenDelayBytes)) begin
                                r_tx_byte <= C_TOKEN_START;
                                r_state   <= S_READ_TOKEN;
                            end else begin
                                r_cnt <= r_cnt + 10'd1;
                            end
                        end
                        S_READ_TOKEN: begin
                            r_tx_byte <= mem_rdata;
                            r_cnt     <= 10'd0;
                            r_state   <= S_READ_DATA;
                        end
                        S_READ_DATA: begin
                            if (r_cnt == 10'd511) begin
                                r_cnt   <= 10'd0;
                                r_state <= S_READ_CRC;
                            end else begin
                                r_tx_byte <= mem_rdata;
                                r_cnt     <= r_cnt + 10'd1;
                            end
                        end
                        S_READ_CRC: begin
                            if (r_cnt == 10'd0) r_cnt   <= 10'd1;
                            else                r_state <= S_IDLE;
                        end
                        S_WRITE_WAIT: begin
                            if (w_rx_byte == C_TOKEN_START) begin
                                r_cnt   <= 10'd0;
                                r_state <= S_WRITE_DATA;
                            end
                        end
                        S_WRITE_DATA: begin
                            mem_we    <= 1'b1;
                            mem_wdata <= w_rx_byte;
                            mem_index <= r_cnt[8:0];
                            if (r_cnt == 10'd511) begin
                                r_cnt   <= 10'd0;
                                r_state <= S_WRITE_CRC;
                            end else begin
                                r_cnt <= r_cnt + 10'd1;
                            end
                        end
                        S_WRITE_CRC: begin
                            if (r_cnt == 10'd0) begin
                                r_cnt <= 10'd1;
                            end else begin
                                r_tx_byte <= C_DATA_RESP_OK;
                                r_state   <= S_DATA_RESP;
                            end
                        end
                        S_DATA_RESP: begin
                            if (BusyBytes == 0) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_tx_byte <= 8'h00;
                                r_cnt     <= 10'd1;
                                r_state   <= S_BUSY;
                            end
                        end
                        S_BUSY: begin
                            if (r_cnt == 10'(BusyBytes)) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_tx_byte <= 8'h00;
                                r_cnt     <= r_cnt + 10'd1;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sd_spi_card_emu.sv
// ============================================================================
// Module : tb_sd_spi_card_emu
// Brief  : Directed host-side bench for sd_spi_card_emu.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sd_spi_card_emu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sd_cs_n = 1'b1;
    logic        sd_clk = 1'b0;
    logic        sd_mosi = 1'b1;
    logic        sd_miso;
    logic [31:0] mem_sector;
    logic [8:0]  mem_index;
    logic [7:0]  mem_rdata = 8'd0;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        initialized;
    logic [31:0] status;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] we_idx [0:1023];
    logic [7:0] we_dat [0:1023];
    int         we_n = 0;

    sd_spi_card_emu dut (
        .clk         (clk),
        .rst         (rst),
        .sd_cs_n     (sd_cs_n),
        .sd_clk      (sd_clk),
        .sd_mosi     (sd_mosi),
        .sd_miso     (sd_miso),
        .mem_sector  (mem_sector),
        .mem_index   (mem_index),
        .mem_rdata   (mem_rdata),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .initialized (initialized),
        .status      (status)
    );

    always #5 clk = ~clk;

    // Storage model: byte i of any sector holds i[7:0], one clk of latency.
    always @(posedge clk) mem_rdata <= mem_index[7:0];

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (we_n < 1024) begin
                we_idx[we_n] = mem_index;
                we_dat[we_n] = mem_wdata;
            end
            we_n = we_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One SPI mode-0 byte; each sd_clk phase is 4 clk.
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            sd_mosi = tx[i];
            #40;
            rx[i] = sd_miso;
            sd_clk = 1'b1;
            #40;
            sd_clk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] tx);
        logic [7:0] rx;
        xfer(tx, rx);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] rx;
        xfer(8'hFF, rx);
        chk(tag, {24'd0, rx}, {24'd0, exp});
    endtask

    task automatic cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
        send({2'b01, idx});
        send(arg[31:24]);
        send(arg[23:16]);
        send(arg[15:8]);
        send(arg[7:0]);
        send(crc);
    endtask

    function automatic logic [7:0] wpat(input int i);
        logic [31:0] v;
        v = i * 7 + 3;
        return v[7:0];
    endfunction

    initial begin
        int base;

        repeat (4) @(negedge clk);
        chk("rst_miso", {31'd0, sd_miso}, 32'd1);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_init", {31'd0, initialized}, 32'd0);
        chk("rst_status", status, 32'd0);
        chk("rst_index", {23'd0, mem_index}, 32'd0);
        chk("rst_sector", mem_sector, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        sd_cs_n = 1'b0;
        #100;

        cmd(6'd0, 32'd0, 8'h95);
        expect_byte("cmd0_ncr", 8'hFF);
        expect_byte("cmd0_r1", 8'h01);
        chk("cmd0_init", {31'd0, initialized}, 32'd0);
        chk("cmd0_idle", status, 32'd0);

        cmd(6'd8, 32'h0000_01AA, 8'h87);
        expect_byte("cmd8_ncr", 8'hFF);
        expect_byte("cmd8_b0", 8'h01);
        expect_byte("cmd8_b1", 8'h00);
        expect_byte("cmd8_b2", 8'h00);
        expect_byte("cmd8_b3", 8'h01);
        expect_byte("cmd8_echo", 8'hAA);

        cmd(6'd41, 32'h4000_0000, 8'hFF);
        expect_byte("cmd41_noapp_ncr", 8'hFF);
        expect_byte("cmd41_noapp_r1", 8'h05);
        chk("cmd41_noapp_init", {31'd0, initialized}, 32'd0);

        cmd(6'd17, 32'd0, 8'hFF);
        expect_byte("cmd17_uninit_ncr", 8'hFF);
        expect_byte("cmd17_uninit_r1", 8'h05);
        expect_byte("cmd17_uninit_idle", 8'hFF);
        chk("cmd17_uninit_state", status, 32'd0);

        cmd(6'd55, 32'd0, 8'hFF);
        expect_byte("cmd55_ncr", 8'hFF);
        expect_byte("cmd55_r1", 8'h01);
        cmd(6'd41, 32'h4000_0000, 8'hFF);
        expect_byte("acmd41_ncr", 8'hFF);
        expect_byte("acmd41_r1", 8'h00);
        chk("acmd41_init", {31'd0, initialized}, 32'd1);

        cmd(6'd58, 32'd0, 8'hFF);
        expect_byte("cmd58_ncr", 8'hFF);
        expect_byte("cmd58_r1", 8'h00);
        expect_byte("cmd58_ocr3", 8'hC0);
        expect_byte("cmd58_ocr2", 8'hFF);
        expect_byte("cmd58_ocr1", 8'h80);
        expect_byte("cmd58_ocr0", 8'h00);

        cmd(6'd16, 32'd512, 8'hFF);
        expect_byte("cmd16_ncr", 8'hFF);
        expect_byte("cmd16_r1", 8'h00);
        cmd(6'd2, 32'd0, 8'hFF);
        expect_byte("cmd2_ncr", 8'hFF);
        expect_byte("cmd2_illegal", 8'h04);

        cmd(6'd17, 32'd7, 8'hFF);
        expect_byte("rd_ncr", 8'hFF);
        expect_byte("rd_r1", 8'h00);
        expect_byte("rd_gap0", 8'hFF);
        expect_byte("rd_gap1", 8'hFF);
        expect_byte("rd_token", 8'hFE);
        for (int i = 0; i < 512; i++) begin
            logic [31:0] iv;
            iv = i;
            expect_byte("rd_data", iv[7:0]);
        end
        expect_byte("rd_crc0", 8'hFF);
        expect_byte("rd_crc1", 8'hFF);
        chk("rd_sector", mem_sector, 32'd7);
        chk("rd_idle", status, 32'd0);
        chk("rd_no_we", we_n, 0);

        cmd(6'd24, 32'd3, 8'hFF);
        expect_byte("wr_ncr", 8'hFF);
        expect_byte("wr_r1", 8'h00);
        send(8'hFF);
        send(8'h00);
        send(8'hFE);
        for (int i = 0; i < 512; i++) send(wpat(i));
        send(8'h12);
        send(8'h34);
        expect_byte("wr_dresp", 8'h05);
        for (int i = 0; i < 4; i++) expect_byte("wr_busy", 8'h00);
        expect_byte("wr_done", 8'hFF);
        chk("wr_sector", mem_sector, 32'd3);
        chk("wr_we_count", we_n, 512);
        for (int i = 0; i < 512; i++) begin
            chk("wr_we_index", {23'd0, we_idx[i]}, i);
            chk("wr_we_data", {24'd0, we_dat[i]}, {24'd0, wpat(i)});
        end
        chk("wr_idle", status, 32'd0);

        base = we_n;
        cmd(6'd24, 32'd5, 8'hFF);
        expect_byte("abort_ncr", 8'hFF);
        expect_byte("abort_r1", 8'h00);
        send(8'hFE);
        for (int i = 0; i < 100; i++) send(wpat(i));
        sd_cs_n = 1'b1;
        #200;
        chk("abort_we_count", we_n - base, 100);
        chk("abort_idle", status, 32'd0);
        chk("abort_miso", {31'd0, sd_miso}, 32'd1);
        chk("abort_init_kept", {31'd0, initialized}, 32'd1);
        sd_cs_n = 1'b0;
        #100;
        cmd(6'd17, 32'd0, 8'hFF);
        expect_byte("after_abort_ncr", 8'hFF);
        expect_byte("after_abort_r1", 8'h00);
        sd_cs_n = 1'b1;
        #200;

        base = we_n;
        sd_cs_n = 1'b0;
        #100;
        cmd(6'd24, 32'd1, 8'hFF);
        expect_byte("rstmid_ncr", 8'hFF);
        expect_byte("rstmid_r1", 8'h00);
        send(8'hFE);
        for (int i = 0; i < 10; i++) send(8'hAA);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) send(8'hAA);
        #100;
        chk("rstmid_we_count", we_n - base, 10);
        chk("rstmid_init", {31'd0, initialized}, 32'd0);
        chk("rstmid_idle", status, 32'd0);
        sd_cs_n = 1'b1;
        #100;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
